// File: rtl/fb_write_bridge_if.sv
// fb_write_bridge_if: processor-store, clear-control and index-RAM write signals of the framebuffer bridge.
interface fb_write_bridge_if #(
  parameter int AW = 19,
  parameter int LW = 5
);
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_data;
  logic          clear_req;
  logic [7:0]    clear_index;
  logic          fb_grant;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_index;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic [15:0]   drop_count;
  modport master (
    output cpu_we, cpu_addr, cpu_data, clear_req, clear_index, fb_grant,
    input  fb_we, fb_addr, fb_index, fifo_full, fifo_level, busy, drop_count
  );
  modport slave (
    input  cpu_we, cpu_addr, cpu_data, clear_req, clear_index, fb_grant,
    output fb_we, fb_addr, fb_index, fifo_full, fifo_level, busy, drop_count
  );
endinterface

// File: rtl/fb_write_bridge.sv
// fb_write_bridge: buffers in-window processor stores and drains them, or a screen clear, into the VGA index RAM on granted cycles.
module fb_write_bridge #(
  parameter logic [31:0] FB_BASE    = 32'h0001_0000,
  parameter int          FB_PIXELS  = 307200,
  parameter int          FIFO_DEPTH = 16,
  parameter int          AW         = 19
) (
  input logic clock_i,
  input logic reset_i,
  fb_write_bridge_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [31:0]   FB_END  = FB_BASE + 32'(FB_PIXELS);
  localparam logic [AW-1:0] BASE_LO = FB_BASE[AW-1:0];
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [AW+7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d, off;
  logic [7:0]    idx_q, idx_d, clr_q, clr_d;
  logic [15:0]   drop_q, drop_d;
  logic          we_q, we_d, hit, full, start, pop, push;
  always_comb begin
    hit   = bus.cpu_we && bus.cpu_addr >= FB_BASE && bus.cpu_addr < FB_END;
    off   = bus.cpu_addr[AW-1:0] - BASE_LO;
    full  = level_q == LW'(FIFO_DEPTH);
    start = state_q == IDLE && bus.clear_req;
    pop   = state_q == IDLE && !bus.clear_req && level_q != '0 && bus.fb_grant;
    // a clear flushes the queue, so a hit on that edge always finds room
    push  = hit && (!full || pop || start);
    wr_d    = wr_q + PW'(push);
    rd_d    = start ? wr_q : rd_q + PW'(pop);
    level_d = start ? LW'(push) : level_q + LW'(push) - LW'(pop);
    drop_d  = (hit && !push && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_d   = clr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    idx_d   = idx_q;
    if (start) begin
      state_d = CLEAR;
      ptr_d   = '0;
      clr_d   = bus.clear_index;
    end else if (pop) begin
      {addr_d, idx_d} = mem[rd_q];
      we_d            = 1'b1;
    end else if (state_q == CLEAR && bus.fb_grant) begin
      we_d    = 1'b1;
      addr_d  = ptr_q;
      idx_d   = clr_q;
      ptr_d   = ptr_q + 1'b1;
      state_d = ptr_q == AW'(FB_PIXELS - 1) ? IDLE : CLEAR;
    end
  end
  always_ff @(posedge clock_i) begin
    if (push) mem[wr_q] <= {off, bus.cpu_data[7:0]};
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ptr_q   <= '0;
      clr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ptr_q   <= ptr_d;
      clr_q   <= clr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end
  assign bus.fb_we      = we_q;
  assign bus.fb_addr    = addr_q;
  assign bus.fb_index   = idx_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_level = level_q;
  assign bus.busy       = state_q == CLEAR;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_fb_write_bridge.sv
// tb_fb_write_bridge: directed stores and clears; expected RAM writes are queued and checked by an independent monitor.
module tb_fb_write_bridge;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int N = 1200;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [26:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;
  fb_write_bridge_if #(.AW(19), .LW(5)) bus ();
  fb_write_bridge #(.FB_BASE(BASE), .FB_PIXELS(N), .FIFO_DEPTH(16), .AW(19)) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.fb_we) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0d idx %0h expected no write", bus.fb_addr, bus.fb_index);
      end else chk("fb_write", {5'd0, bus.fb_addr, bus.fb_index}, {5'd0, exp_q.pop_front()});
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [7:0] d);
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_data = {24'hABCDEF, d};
    tick();
    bus.cpu_we   = 1'b0;
  endtask
  task automatic wait_busy_low(input int lim);
    for (int i = 0; i < lim && bus.busy; i++) tick();
    chk("busy_end", {31'd0, bus.busy}, 32'd0);
  endtask
  initial begin
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.clear_req = 1'b0;
    bus.clear_index = '0;
    bus.fb_grant = 1'b0;
    tick(2);
    chk("rst_we", {31'd0, bus.fb_we}, 0);
    chk("rst_addr", {13'd0, bus.fb_addr}, 0);
    chk("rst_index", {24'd0, bus.fb_index}, 0);
    chk("rst_level", {27'd0, bus.fifo_level}, 0);
    chk("rst_full", {31'd0, bus.fifo_full}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_drop", {16'd0, bus.drop_count}, 0);
    rst = 1'b0;
    tick();
    bus.fb_grant = 1'b1;
    exp_q.push_back({19'd5, 8'hA3});
    store(BASE + 5, 8'hA3);
    chk("no_bypass", {31'd0, bus.fb_we}, 0);
    tick();
    chk("latency_we", {31'd0, bus.fb_we}, 1);
    tick();
    chk("single_pulse", {31'd0, bus.fb_we}, 0);
    chk("t1_level", {27'd0, bus.fifo_level}, 0);
    store(BASE - 1, 8'h11);
    store(BASE + N, 8'h22);
    store(32'h0, 8'h33);
    tick(3);
    chk("oow_level", {27'd0, bus.fifo_level}, 0);
    chk("oow_drop", {16'd0, bus.drop_count}, 0);
    bus.fb_grant = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back({19'(i), 8'(i)});
      store(BASE + 32'(i), 8'(i));
    end
    chk("t3_full", {31'd0, bus.fifo_full}, 1);
    chk("t3_level", {27'd0, bus.fifo_level}, 16);
    chk("t3_drop", {16'd0, bus.drop_count}, 2);
    bus.fb_grant = 1'b1;
    tick(20);
    chk("t3_drained", {27'd0, bus.fifo_level}, 0);
    chk("t3_not_full", {31'd0, bus.fifo_full}, 0);
    bus.fb_grant = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({19'(100 + i), 8'(8'hC0 + i)});
      store(BASE + 32'(100 + i), 8'(8'hC0 + i));
    end
    chk("t4_full", {31'd0, bus.fifo_full}, 1);
    exp_q.push_back({19'd300, 8'hEE});
    bus.fb_grant = 1'b1;
    store(BASE + 300, 8'hEE);
    chk("t4_level_kept", {27'd0, bus.fifo_level}, 16);
    chk("t4_no_drop", {16'd0, bus.drop_count}, 2);
    tick(20);
    chk("t4_drained", {27'd0, bus.fifo_level}, 0);
    bus.fb_grant = 1'b0;
    for (int i = 0; i < 3; i++) store(BASE + 32'(200 + i), 8'h99);
    bus.clear_req = 1'b1;
    bus.clear_index = 8'h07;
    store(BASE + 9, 8'h55);
    bus.clear_req = 1'b0;
    chk("clr_busy", {31'd0, bus.busy}, 1);
    chk("clr_flush_level", {27'd0, bus.fifo_level}, 1);
    for (int p = 0; p < N; p++) exp_q.push_back({19'(p), 8'h07});
    exp_q.push_back({19'd9, 8'h55});
    bus.fb_grant = 1'b1;
    tick(5);
    bus.clear_req = 1'b1;
    bus.clear_index = 8'h33;
    tick();
    bus.clear_req = 1'b0;
    wait_busy_low(N + 20);
    tick(5);
    chk("clr_level", {27'd0, bus.fifo_level}, 0);
    chk("clr_all_seen", 32'(exp_q.size()), 0);
    bus.clear_index = 8'h11;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int p = 0; p < 1000; p++) exp_q.push_back({19'(p), 8'h11});
    tick(1000);
    #5;
    rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, bus.fb_we}, 0);
    chk("arst_busy", {31'd0, bus.busy}, 0);
    chk("arst_level", {27'd0, bus.fifo_level}, 0);
    tick(2);
    rst = 1'b0;
    chk("arst_seen", 32'(exp_q.size()), 0);
    bus.clear_index = 8'h22;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk("restart_busy", {31'd0, bus.busy}, 1);
    for (int p = 0; p < N; p++) exp_q.push_back({19'(p), 8'h22});
    wait_busy_low(N + 20);
    tick(3);
    chk("restart_all_seen", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
